// File: rtl/fetch_refill_ctrl.sv
// I-cache line refill sequencer: one miss -> one line-aligned AXI read -> beats
// drained from the response FIFO and assembled into a line for the fill port.

module fetch_refill_beat_slot #(
    parameter int BEAT_W = 64
) (
    input  logic              cpu_clk,
    input  logic              cpu_reset,
    input  logic              clr,
    input  logic              wr,
    input  logic [BEAT_W-1:0] wdata,
    output logic [BEAT_W-1:0] q
);
    always_ff @(posedge cpu_clk) begin
        if (cpu_reset || clr) q <= '0;
        else if (wr)          q <= wdata;
    end
endmodule

module fetch_refill_ctrl #(
    parameter  int ADDR_W         = 64,
    parameter  int BEAT_W         = 64,
    parameter  int BEATS_PER_LINE = 8,
    localparam int LINE_W         = BEAT_W * BEATS_PER_LINE
) (
    input  logic              cpu_clk,
    input  logic              cpu_reset,
    input  logic              miss_valid_i,
    input  logic [ADDR_W-1:0] miss_addr_i,
    output logic              miss_ready_o,
    output logic              ar_valid_o,
    output logic [ADDR_W-1:0] ar_addr_o,
    input  logic              ar_ready_i,
    output logic              fifo_rd_en_o,
    input  logic              fifo_rd_empty_i,
    input  logic              fifo_rd_valid_i,
    input  logic [BEAT_W-1:0] fifo_rd_data_i,
    input  logic              fifo_rd_err_i,
    input  logic              flush_i,
    output logic              fill_valid_o,
    output logic [ADDR_W-1:0] fill_addr_o,
    output logic [LINE_W-1:0] fill_data_o,
    output logic              fill_err_o
);
    localparam int IDX_W = $clog2(BEATS_PER_LINE);
    localparam int CNT_W = IDX_W + 1;
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0]  FULL     = CNT_W'(BEATS_PER_LINE);
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(BEATS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    typedef enum logic [2:0] {IDLE, REQ, FILL, DRAIN, DONE} state_t;

    state_t                               state, state_nxt;
    logic [ADDR_W-1:0]                    line_addr;
    logic [BEATS_PER_LINE-1:0][BEAT_W-1:0] line_buf;
    logic                                 line_err;
    logic                                 kill;
    logic [CNT_W-1:0]                     issued_cnt, rcvd_cnt;
    logic                                 miss_fire, busy, rcv, last_rcv, fill_wr;

    assign busy      = (state == FILL) || (state == DRAIN);
    assign miss_fire = miss_valid_i && miss_ready_o;
    // Beats outside FILL/DRAIN or beyond the line are protocol errors and ignored.
    assign rcv       = busy && fifo_rd_valid_i && (rcvd_cnt < FULL);
    assign last_rcv  = rcv && (rcvd_cnt == LAST);
    assign fill_wr   = rcv && (state == FILL);

    always_comb begin
        state_nxt    = state;
        miss_ready_o = 1'b0;
        ar_valid_o   = 1'b0;
        fifo_rd_en_o = 1'b0;
        fill_valid_o = 1'b0;
        case (state)
            IDLE: begin
                miss_ready_o = ~flush_i & ~cpu_reset;
                if (miss_valid_i && miss_ready_o) state_nxt = REQ;
            end
            REQ: begin
                // A flushed request still goes out; its beats get drained later.
                ar_valid_o = 1'b1;
                if (ar_ready_i) state_nxt = (kill || flush_i) ? DRAIN : FILL;
            end
            FILL: begin
                fifo_rd_en_o = ~fifo_rd_empty_i & (issued_cnt < FULL);
                if (flush_i)       state_nxt = last_rcv ? IDLE : DRAIN;
                else if (last_rcv) state_nxt = DONE;
            end
            DRAIN: begin
                fifo_rd_en_o = ~fifo_rd_empty_i & (issued_cnt < FULL);
                if (last_rcv) state_nxt = IDLE;
            end
            DONE: begin
                fill_valid_o = ~flush_i;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_reset) begin
            state      <= IDLE;
            line_addr  <= '0;
            line_err   <= 1'b0;
            kill       <= 1'b0;
            issued_cnt <= '0;
            rcvd_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && miss_fire) begin
                line_addr  <= miss_addr_i & ~OFF_MASK;
                line_err   <= 1'b0;
                kill       <= 1'b0;
                issued_cnt <= '0;
                rcvd_cnt   <= '0;
            end
            if (state == REQ && flush_i) kill <= 1'b1;
            if (fifo_rd_en_o) issued_cnt <= issued_cnt + 1'b1;
            if (rcv)          rcvd_cnt   <= rcvd_cnt + 1'b1;
            if (fill_wr)      line_err   <= line_err | fifo_rd_err_i;
        end
    end

    for (genvar k = 0; k < BEATS_PER_LINE; k++) begin : g_slot
        fetch_refill_beat_slot #(.BEAT_W(BEAT_W)) u_slot (
            .cpu_clk  (cpu_clk),
            .cpu_reset(cpu_reset),
            .clr      (state == IDLE && miss_fire),
            .wr       (fill_wr && (rcvd_cnt[IDX_W-1:0] == IDX_W'(k))),
            .wdata    (fifo_rd_data_i),
            .q        (line_buf[k])
        );
    end

    assign ar_addr_o   = line_addr;
    assign fill_addr_o = line_addr;
    assign fill_data_o = line_buf;
    assign fill_err_o  = line_err;
endmodule

// File: tb/tb_fetch_refill_ctrl.sv
// Bench for fetch_refill_ctrl: queue-based response FIFO and per-line expectations,
// directed scenarios followed by randomized refills.

module tb_fetch_refill_ctrl;
    logic         cpu_clk, cpu_reset;
    logic         miss_valid_i, miss_ready_o;
    logic [63:0]  miss_addr_i, ar_addr_o, fill_addr_o;
    logic         ar_valid_o, ar_ready_i;
    logic         fifo_rd_en_o, fifo_rd_empty_i, fifo_rd_valid_i, fifo_rd_err_i;
    logic [63:0]  fifo_rd_data_i;
    logic         flush_i, fill_valid_o, fill_err_o;
    logic [511:0] fill_data_o;

    fetch_refill_ctrl dut (
        .cpu_clk(cpu_clk), .cpu_reset(cpu_reset),
        .miss_valid_i(miss_valid_i), .miss_addr_i(miss_addr_i), .miss_ready_o(miss_ready_o),
        .ar_valid_o(ar_valid_o), .ar_addr_o(ar_addr_o), .ar_ready_i(ar_ready_i),
        .fifo_rd_en_o(fifo_rd_en_o), .fifo_rd_empty_i(fifo_rd_empty_i),
        .fifo_rd_valid_i(fifo_rd_valid_i), .fifo_rd_data_i(fifo_rd_data_i),
        .fifo_rd_err_i(fifo_rd_err_i), .flush_i(flush_i),
        .fill_valid_o(fill_valid_o), .fill_addr_o(fill_addr_o),
        .fill_data_o(fill_data_o), .fill_err_o(fill_err_o)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    typedef struct { logic [63:0] d; logic e; } beat_t;
    beat_t q[$];

    int checks = 0, errors = 0;
    int cyc = 0, pops, delivered, pulses, accept_cyc, pulse_cyc;
    int gate_mode = 0, ar_wait = 0, flush_mode = 0, flush_at = 0;
    bit accepted, flushed, rdy;
    logic [63:0]  exp_ar, got_addr;
    logic [511:0] got_data;
    logic         got_err;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_miss_ready"}, miss_ready_o, 0);
        chk({tag, "_ar_valid"},   ar_valid_o,   0);
        chk({tag, "_rd_en"},      fifo_rd_en_o, 0);
        chk({tag, "_fill_valid"}, fill_valid_o, 0);
        chk({tag, "_fill_err"},   fill_err_o,   0);
        chk({tag, "_fill_addr"},  fill_addr_o,  0);
        chk({tag, "_fill_data"},  fill_data_o,  0);
    endtask

    // One clock: sample at negedge, then model the FIFO/AXI side after the posedge.
    task automatic tick();
        bit en, pop, acc, arv;
        beat_t b;
        @(negedge cpu_clk);
        cyc++;
        en  = fifo_rd_en_o;
        pop = en && !fifo_rd_empty_i;
        if (en) chk("pop_while_empty", fifo_rd_empty_i, 0);
        if (pop) pops++;
        arv = ar_valid_o;
        if (arv) chk("ar_addr", ar_addr_o, exp_ar);
        if (fill_valid_o) begin
            pulses++; pulse_cyc = cyc;
            got_data = fill_data_o; got_addr = fill_addr_o; got_err = fill_err_o;
        end
        rdy = miss_ready_o;
        acc = miss_valid_i && miss_ready_o;
        if (acc) begin accepted = 1; accept_cyc = cyc; end
        @(posedge cpu_clk);
        #1;
        if (acc) miss_valid_i = 1'b0;
        fifo_rd_valid_i = 1'b0;
        if (cpu_reset) q.delete();
        else if (pop && q.size() > 0) begin
            b = q.pop_front();
            fifo_rd_valid_i = 1'b1; fifo_rd_data_i = b.d; fifo_rd_err_i = b.e;
            delivered++;
        end
        fifo_rd_empty_i = (q.size() == 0) || (gate_mode == 1 && cyc[0]) ||
                          (gate_mode == 2 && $urandom_range(0, 2) == 0);
        if (arv && !ar_ready_i) begin
            ar_wait--;
            if (ar_wait <= 0) ar_ready_i = 1'b1;
        end
        flush_i = 1'b0;
        if (!flushed && flush_mode == 1 && delivered == flush_at) begin flush_i = 1'b1; flushed = 1; end
        if (!flushed && flush_mode == 2 && arv) begin flush_i = 1'b1; flushed = 1; end
    endtask

    // fmode: 0 none, 1 flush once fat beats delivered, 2 flush while request pending.
    task automatic refill(input logic [63:0] addr, input int fmode, input int fat, input int gmode,
                          input int arw, input int errbeat, input bit seqd, input int rst_at,
                          input string tag);
        logic [511:0] line;
        logic lerr;
        int n;
        line = '0; lerr = 1'b0;
        for (int k = 0; k < 8; k++) begin
            beat_t b;
            b.d = seqd ? 64'(k) : {$urandom(), $urandom()};
            b.e = (k == errbeat);
            q.push_back(b);
            line[k*64 +: 64] = b.d;
            lerr |= b.e;
        end
        pops = 0; delivered = 0; pulses = 0; accepted = 0; flushed = 0;
        flush_mode = fmode; flush_at = fat; gate_mode = gmode;
        ar_wait = arw; ar_ready_i = (arw == 0);
        exp_ar = addr & ~64'h3F;
        fifo_rd_empty_i = 1'b0;
        miss_addr_i = addr; miss_valid_i = 1'b1;
        n = 0;
        while (!accepted && n < 50) begin tick(); n++; end
        chk({tag, "_accept"}, accepted, 1);
        miss_valid_i = 1'b0;
        if (rst_at >= 0) begin
            n = 0;
            while (delivered < rst_at && n < 100) begin tick(); n++; end
            chk({tag, "_reached_beat"}, delivered, rst_at);
            cpu_reset = 1'b1;
            tick();
            @(negedge cpu_clk);
            chk_reset({tag, "_midrst"});
            @(posedge cpu_clk); #1;
            cpu_reset = 1'b0; fifo_rd_valid_i = 1'b0; fifo_rd_empty_i = 1'b1;
        end else begin
            n = 0;
            while (!(delivered == 8 && rdy) && n < 200) begin tick(); n++; end
            chk({tag, "_complete"}, (delivered == 8 && rdy), 1);
            chk({tag, "_pops"}, pops, 8);
            chk({tag, "_pulses"}, pulses, (fmode == 0) ? 1 : 0);
            if (fmode == 0) begin
                chk({tag, "_fill_addr"}, got_addr, exp_ar);
                chk({tag, "_fill_data"}, got_data, line);
                chk({tag, "_fill_err"},  got_err,  lerr);
            end
        end
        flush_mode = 0; gate_mode = 0;
    endtask

    initial begin
        cpu_reset = 1'b1; miss_valid_i = 1'b0; miss_addr_i = '0; ar_ready_i = 1'b0;
        fifo_rd_empty_i = 1'b1; fifo_rd_valid_i = 1'b0; fifo_rd_data_i = '0;
        fifo_rd_err_i = 1'b0; flush_i = 1'b0; exp_ar = '0;
        repeat (3) @(posedge cpu_clk);
        @(negedge cpu_clk);
        chk_reset("reset");
        @(posedge cpu_clk); #1;
        cpu_reset = 1'b0;

        // flush in IDLE blocks the miss handshake for that cycle
        accepted = 0;
        miss_valid_i = 1'b1; miss_addr_i = 64'h40; flush_i = 1'b1;
        tick();
        chk("idle_flush_ready", rdy, 0);
        chk("idle_flush_accept", accepted, 0);
        miss_valid_i = 1'b0;
        tick();

        refill(64'h1234, 0, 0, 0, 0, -1, 1, -1, "t1");
        chk("t1_ar_addr_const", exp_ar, 64'h1200);
        chk("t1_latency", pulse_cyc - accept_cyc, 11);
        refill(64'h1234, 0, 0, 1, 0, -1, 1, -1, "t2");
        refill(64'h5678, 1, 3, 0, 0, -1, 0, -1, "t3");
        refill(64'h2040, 0, 0, 0, 0, -1, 0, -1, "t3b");
        refill(64'h9abc, 2, 0, 0, 4, -1, 0, -1, "t4");
        refill(64'h3008, 0, 0, 0, 0,  5, 0, -1, "t5");
        refill(64'h3048, 0, 0, 0, 1, -1, 0, -1, "t5b");
        refill(64'h4100, 0, 0, 0, 0, -1, 0,  4, "t6");
        refill(64'h4140, 0, 0, 0, 0, -1, 0, -1, "t6b");

        for (int i = 0; i < 20; i++) begin
            int r, fm, eb;
            r  = $urandom_range(0, 5);
            fm = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            refill({$urandom(), $urandom()}, fm, int'($urandom_range(1, 7)),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), eb, 0, -1, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
